// File: rtl/arccos_solver.sv
// Iterative arccos: bisects the angle in [0,402] (Q2.8 radians) against a 6th-order Taylor cosine.
// Define ACOS_ERR_EN to add the err port and reject operands above 1.0 instead of saturating them.
module arccos_solver (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] c,
   output logic       ready,
   output logic [9:0] angle
`ifdef ACOS_ERR_EN
   ,
   output logic       err
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, SQ, P4, P6, SUM, CMP} state_t;

   localparam logic [9:0] C_ONE   = 10'h100;
   localparam logic [8:0] HI_INIT = 9'd402;

   state_t             state_q;
   logic [8:0]         c_q, lo_q, hi_q, mid_q;
   logic [15:0]        x2_q;
   logic [16:0]        x4_q;
   logic [17:0]        x6_q;
   logic signed [17:0] acc_q;
   logic               ready_q;
   logic [9:0]         angle_q;
`ifdef ACOS_ERR_EN
   logic               err_q;
`endif

   logic [9:0]         sum_c;
   logic [8:0]         mid_c;
   logic [17:0]        mul_a;
   logic [15:0]        mul_b;
   logic [33:0]        prod;
   logic signed [17:0] prod_hi, cos_c, thr_c;
   logic               le_c;
   logic [8:0]         lo_d, hi_d;
   logic               unused_bits;

   function automatic logic [8:0] sat_operand(input logic [9:0] v);
      return (v > C_ONE) ? C_ONE[8:0] : v[8:0];
   endfunction

   assign sum_c = {1'b0, lo_q} + {1'b0, hi_q};
   assign mid_c = sum_c[9:1];

   // x4 and x6 exceed 2.0 near pi/2, so the shared multiplier takes an 18-bit A operand
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state_q)
         SQ:  begin mul_a = {9'b0, mid_c}; mul_b = {7'b0, mid_c}; end
         P4:  begin mul_a = {2'b0, x2_q};  mul_b = x2_q;          end
         P6:  begin mul_a = {1'b0, x4_q};  mul_b = x2_q;          end
         SUM: begin mul_a = {1'b0, x4_q};  mul_b = 16'd2731;      end
         CMP: begin mul_a = x6_q;          mul_b = 16'd91;        end
         default: ;
      endcase
   end

   assign prod        = {16'b0, mul_a} * {18'b0, mul_b};
   assign prod_hi     = $signed({1'b0, prod[32:16]});
   assign cos_c       = acc_q - prod_hi;
   assign thr_c       = $signed({3'b0, c_q, 6'b0});
   assign le_c        = (cos_c <= thr_c);
   assign lo_d        = le_c ? lo_q : mid_q + 9'd1;
   assign hi_d        = le_c ? mid_q : hi_q;
   assign unused_bits = ^{prod[33], prod[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         mid_q   <= '0;
         x2_q    <= '0;
         x4_q    <= '0;
         x6_q    <= '0;
         acc_q   <= '0;
         ready_q <= 1'b1;
         angle_q <= '0;
`ifdef ACOS_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LOAD;
                  ready_q <= 1'b0;
`ifdef ACOS_ERR_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            LOAD: begin
`ifdef ACOS_ERR_EN
               if (c > C_ONE) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  angle_q <= '0;
                  err_q   <= 1'b1;
               end else
`endif
               begin
                  c_q     <= sat_operand(c);
                  lo_q    <= '0;
                  hi_q    <= HI_INIT;
                  state_q <= SQ;
               end
            end
            SQ: begin
               mid_q   <= mid_c;
               x2_q    <= prod[17:2];
               acc_q   <= 18'sd16384 - $signed({3'b0, prod[17:3]});
               state_q <= P4;
            end
            P4: begin
               x4_q    <= prod[30:14];
               state_q <= P6;
            end
            P6: begin
               x6_q    <= prod[31:14];
               state_q <= SUM;
            end
            SUM: begin
               acc_q   <= acc_q + prod_hi;
               state_q <= CMP;
            end
            CMP: begin
               acc_q <= cos_c;
               lo_q  <= lo_d;
               hi_q  <= hi_d;
               if (lo_d != hi_d) begin
                  state_q <= SQ;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  angle_q <= {1'b0, lo_d};
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready = ready_q;
   assign angle = angle_q;
`ifdef ACOS_ERR_EN
   assign err   = err_q;
`endif

endmodule

// File: tb/tb_arccos_solver.sv
// Directed bench for arccos_solver: vector table plus hand-written start-hold and mid-run reset sequences.
// Works with or without ACOS_ERR_EN defined.
module tb_arccos_solver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [9:0] c = '0;
   logic       ready;
   logic [9:0] angle;
`ifdef ACOS_ERR_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] c;
      logic [9:0] angle;
      int         lat;
      logic       err;
   } vec_t;

   arccos_solver dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .c     (c),
      .ready (ready),
      .angle (angle)
`ifdef ACOS_ERR_EN
      ,
      .err   (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // lat counts the start-sampling edge as 1; ready is seen high after edge lat
   task automatic run_op(input logic [9:0] cv, output int lat,
                         output logic brdy, output logic [9:0] bang);
      @(negedge clk);
      c     = cv;
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      brdy  = ready;
      bang  = angle;
      while (!ready && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      vec_t       tv[6];
      int         lat;
      logic       brdy;
      logic [9:0] bang;
      logic [9:0] prev;

      tv[0] = '{10'h100, 10'h000, 47, 1'b0};
      tv[1] = '{10'h080, 10'h10D, 47, 1'b0};
      tv[2] = '{10'h000, 10'h192, 42, 1'b0};
      tv[3] = '{10'h0C0, 10'h0BA, 42, 1'b0};
      tv[4] = '{10'h0FF, 10'h017, 47, 1'b0};
`ifdef ACOS_ERR_EN
      tv[5] = '{10'h1FF, 10'h000, 2, 1'b1};
`else
      tv[5] = '{10'h1FF, 10'h000, 47, 1'b0};
`endif

      #1 rst = 1'b0;
      #1;
      check("reset_ready", int'(ready), 1);
      check("reset_angle", int'(angle), 0);
`ifdef ACOS_ERR_EN
      check("reset_err", int'(err), 0);
`endif
      @(negedge clk);
      rst = 1'b1;

      prev = '0;
      for (int i = 0; i < 6; i++) begin
         run_op(tv[i].c, lat, brdy, bang);
         check($sformatf("v%0d_busy_ready", i), int'(brdy), 0);
         check($sformatf("v%0d_angle_held", i), int'(bang), int'(prev));
         check($sformatf("v%0d_angle", i), int'(angle), int'(tv[i].angle));
         check($sformatf("v%0d_latency", i), lat, tv[i].lat);
`ifdef ACOS_ERR_EN
         check($sformatf("v%0d_err", i), int'(err), int'(tv[i].err));
`endif
         prev = tv[i].angle;
      end

      // start held high throughout, operand changed after capture
      @(negedge clk);
      c     = 10'h080;
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      while (!ready && lat < 60) begin
         if (lat == 5) c = 10'h000;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("hold_angle", int'(angle), 'h10D);
      check("hold_latency", lat, 47);
      @(posedge clk);
      @(negedge clk);
      check("hold_restart_ready", int'(ready), 0);
      check("hold_restart_angle", int'(angle), 'h10D);
      start = 1'b0;
      lat   = 1;
      while (!ready && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("second_angle", int'(angle), 'h192);
      check("second_latency", lat, 42);

      // asynchronous reset in the middle of a computation
      @(negedge clk);
      c     = 10'h080;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_ready", int'(ready), 1);
      check("midrst_angle", int'(angle), 0);
`ifdef ACOS_ERR_EN
      check("midrst_err", int'(err), 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      run_op(10'h100, lat, brdy, bang);
      check("post_rst_busy", int'(brdy), 0);
      check("post_rst_angle", int'(angle), 0);
      check("post_rst_latency", lat, 47);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
